// File: rtl/blue_motion_ctrl.sv
// -----------------------------------------------------------------------------
// blue_motion_ctrl
//   Position producer for the blue character. On every frame_tick it reads the
//   4-bit collision flags and the keys, then updates x_blue/y_blue. It handles
//   walking, the GROUND/RISE/FALL jump state machine, gravity and clamping to
//   the screen.
//
//   Optional feature macro: DOUBLE_JUMP_EN
//     defined   : one extra jump is allowed while airborne (RISE or FALL).
//     undefined : a jump request made in the air is discarded at that tick.
//
// Ports
//   clk           in   1   system clock
//   rst_n         in   1   synchronous, active-low reset
//   frame_tick    in   1   one-cycle pulse per frame; motion updates only here
//   key_left      in   1   level, walk left
//   key_right     in   1   level, walk right
//   key_jump      in   1   level, jump key (rising edge = request)
//   is_Collision  in   4   [0]=down [1]=up [2]=right [3]=left contact
//   x_blue        out  10  sprite left x (registered)
//   y_blue        out  9   sprite top y (registered)
//   state         out  2   0=GROUND 1=RISE 2=FALL (3 recovers to FALL)
//   on_ground     out  1   state==GROUND
// -----------------------------------------------------------------------------
module blue_motion_ctrl #(
  parameter logic [9:0] X_INIT  = 10'd40,
  parameter logic [8:0] Y_INIT  = 9'd400,
  parameter int         H_SPEED = 3,
  parameter int         JUMP_V  = 12,
  parameter int         GRAVITY = 1,
  parameter int         V_MAX   = 8,
  parameter logic [9:0] X_MAX   = 10'd593,
  parameter logic [8:0] Y_MAX   = 9'd439
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic [3:0] is_Collision,
  output logic [9:0] x_blue,
  output logic [8:0] y_blue,
  output logic [1:0] state,
  output logic       on_ground
);

  localparam logic [1:0] ST_GROUND = 2'd0;
  localparam logic [1:0] ST_RISE   = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;

  localparam logic [10:0] H_STEP  = 11'(H_SPEED);
  localparam logic [4:0]  V_JUMP  = 5'(JUMP_V);
  localparam logic [5:0]  V_GRAV  = 6'(GRAVITY);
  localparam logic [5:0]  V_TERM  = 6'(V_MAX);
  localparam logic [10:0] X_LIMIT = {1'b0, X_MAX};
  localparam logic [9:0]  Y_LIMIT = {1'b0, Y_MAX};

  logic [1:0] state_q, state_d;
  logic [4:0] vy_q, vy_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       key_jump_q;
  logic       jump_req_q;
  logic       jump_now;
  logic       air_jump_go;

  // A rising edge seen on the tick cycle itself still counts for that tick.
  assign jump_now = jump_req_q | (key_jump & ~key_jump_q);

  // ---------------------------------------------------------------------------
  // Jump request latch. Every tick clears it: either the jump was taken or
  // it was not allowed, so a request never survives into a later air phase.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_jump_q <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      key_jump_q <= key_jump;
      if (frame_tick) begin
        jump_req_q <= 1'b0;
      end else if (key_jump & ~key_jump_q) begin
        jump_req_q <= 1'b1;
      end
    end
  end

`ifdef DOUBLE_JUMP_EN
  logic air_jump_used_q, air_jump_used_d;

  assign air_jump_go = jump_now & ~air_jump_used_q;

  always_comb begin
    air_jump_used_d = air_jump_used_q;
    if (frame_tick) begin
      if (state_q == ST_GROUND || state_d == ST_GROUND) begin
        air_jump_used_d = 1'b0;
      end else if (air_jump_go && (state_q == ST_RISE || state_q == ST_FALL)) begin
        air_jump_used_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      air_jump_used_q <= 1'b0;
    end else begin
      air_jump_used_q <= air_jump_used_d;
    end
  end
`else
  assign air_jump_go = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Vertical arithmetic, done 10 bits wide and clamped back into 9 bits.
  // ---------------------------------------------------------------------------
  logic [9:0] y_wide, vy_wide, y_up_wide, y_dn_sum;
  logic [8:0] y_up, y_dn;
  logic [5:0] vy_inc_sum;
  logic [4:0] vy_dec, vy_inc;
  logic       rise_end;

  always_comb begin
    y_wide     = {1'b0, y_q};
    vy_wide    = {5'd0, vy_q};
    y_up_wide  = (y_wide < vy_wide) ? 10'd0 : (y_wide - vy_wide);
    y_up       = y_up_wide[8:0];
    y_dn_sum   = y_wide + vy_wide;
    y_dn       = (y_dn_sum > Y_LIMIT) ? Y_MAX : y_dn_sum[8:0];
    vy_dec     = ({1'b0, vy_q} <= V_GRAV) ? 5'd0 : (vy_q - V_GRAV[4:0]);
    vy_inc_sum = {1'b0, vy_q} + V_GRAV;
    vy_inc     = (vy_inc_sum >= V_TERM) ? V_TERM[4:0] : vy_inc_sum[4:0];
    rise_end   = (vy_dec == 5'd0) || (y_up == 9'd0);
  end

  // ---------------------------------------------------------------------------
  // Horizontal step: both or neither key holds x.
  // ---------------------------------------------------------------------------
  logic       left_only, right_only;
  logic [10:0] x_right_sum;

  always_comb begin
    left_only   = key_left & ~key_right;
    right_only  = key_right & ~key_left;
    x_right_sum = {1'b0, x_q} + H_STEP;
    x_d         = x_q;
    if (left_only && !is_Collision[3]) begin
      x_d = ({1'b0, x_q} < H_STEP) ? 10'd0 : (x_q - H_STEP[9:0]);
    end else if (right_only && !is_Collision[2]) begin
      x_d = (x_right_sum > X_LIMIT) ? X_MAX : x_right_sum[9:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 1: state and motion registers, updated only on frame_tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FALL;
      vy_q    <= 5'd0;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
    end else if (frame_tick) begin
      state_q <= state_d;
      vy_q    <= vy_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state with its vertical position and speed.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    vy_d    = vy_q;
    y_d     = y_q;
    case (state_q)
      ST_GROUND: begin
        vy_d = 5'd0;
        if (jump_now) begin
          state_d = ST_RISE;
          vy_d    = V_JUMP;
        end else if (!is_Collision[0] && y_q < Y_MAX) begin
          state_d = ST_FALL;
        end
      end
      ST_RISE: begin
        if (air_jump_go) begin
          vy_d = V_JUMP;
        end else if (is_Collision[1]) begin
          // Head bump wins over a simultaneous floor contact.
          state_d = ST_FALL;
          vy_d    = 5'd0;
        end else begin
          y_d = y_up;
          if (rise_end) begin
            state_d = ST_FALL;
            vy_d    = 5'd0;
          end else begin
            vy_d = vy_dec;
          end
        end
      end
      ST_FALL: begin
        if (air_jump_go) begin
          state_d = ST_RISE;
          vy_d    = V_JUMP;
        end else if (is_Collision[0] || y_q == Y_MAX) begin
          state_d = ST_GROUND;
          vy_d    = 5'd0;
        end else begin
          // Reaching Y_MAX here lands on the following tick.
          y_d  = y_dn;
          vy_d = vy_inc;
        end
      end
      default: begin
        state_d = ST_FALL;
        vy_d    = 5'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_blue    = x_q;
    y_blue    = y_q;
    state     = state_q;
    on_ground = (state_q == ST_GROUND);
  end

endmodule

// File: tb/tb_blue_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_blue_motion_ctrl
//   Directed bench for blue_motion_ctrl: a table of per-frame vectors with
//   hand-computed positions, then hand-written sequences for air jumps, screen
//   clamping, landing at the bottom edge and reset in mid-jump.
// -----------------------------------------------------------------------------
module tb_blue_motion_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic [3:0] is_Collision;
  logic [9:0] x_blue;
  logic [8:0] y_blue;
  logic [1:0] state;
  logic       on_ground;

  int n_checks;
  int n_fails;

  blue_motion_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_jump     (key_jump),
    .is_Collision (is_Collision),
    .x_blue       (x_blue),
    .y_blue       (y_blue),
    .state        (state),
    .on_ground    (on_ground)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    frame_tick   = 1'b0;
    key_left     = 1'b0;
    key_right    = 1'b0;
    key_jump     = 1'b0;
    is_Collision = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge, outputs sampled there too)
  // ---------------------------------------------------------------------------
  task automatic do_tick(input logic l, input logic r, input logic j, input logic [3:0] c);
    @(negedge clk);
    key_left     = l;
    key_right    = r;
    key_jump     = j;
    is_Collision = c;
    frame_tick   = 1'b1;
    @(negedge clk);
    frame_tick   = 1'b0;
    key_jump     = 1'b0;
  endtask

  task automatic pulse_jump();
    @(negedge clk);
    key_jump = 1'b1;
    @(negedge clk);
    key_jump = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [9:0] ex, input logic [8:0] ey,
                       input logic [1:0] es);
    logic exp_og;
    exp_og = (es == 2'd0);
    n_checks++;
    if (x_blue !== ex) begin
      n_fails++;
      $display("FAIL %s x_blue: got %0d expected %0d", name, x_blue, ex);
    end
    n_checks++;
    if (y_blue !== ey) begin
      n_fails++;
      $display("FAIL %s y_blue: got %0d expected %0d", name, y_blue, ey);
    end
    n_checks++;
    if (state !== es) begin
      n_fails++;
      $display("FAIL %s state: got %0d expected %0d", name, state, es);
    end
    n_checks++;
    if (on_ground !== exp_og) begin
      n_fails++;
      $display("FAIL %s on_ground: got %0b expected %0b", name, on_ground, exp_og);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: one row per frame tick
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       l;
    logic       r;
    logic       j;      // jump pulse before the tick
    logic [3:0] c;
    logic [9:0] ex;
    logic [8:0] ey;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[22];

  initial begin
    logic [8:0] ground_y;
    logic [9:0] mdl_y;
    logic [4:0] mdl_vy;
    bit         landed;
    string      nm;

    n_checks = 0;
    n_fails  = 0;

    // Fall from reset, land, full jump, head bump, walk off a ledge.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd400, 2'd2};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd401, 2'd2};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd403, 2'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'b0001, 10'd40, 9'd403, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'b0001, 10'd40, 9'd403, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 10'd43, 9'd391, 2'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd380, 2'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 10'd40, 9'd370, 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd361, 2'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd353, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd346, 2'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd340, 2'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd335, 2'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd331, 2'd1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd328, 2'd1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd326, 2'd1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd325, 2'd2};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 4'b0001, 10'd40, 9'd325, 2'd0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 4'b0001, 10'd40, 9'd325, 2'd1};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 4'b0011, 10'd40, 9'd325, 2'd2};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 4'b0001, 10'd40, 9'd325, 2'd0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 4'b0000, 10'd40, 9'd325, 2'd2};

    do_reset();
    check("reset", 10'd40, 9'd400, 2'd2);

    // Outputs hold when no frame tick is present.
    @(negedge clk);
    key_right = 1'b1;
    @(negedge clk);
    @(negedge clk);
    key_right = 1'b0;
    check("no_tick_hold", 10'd40, 9'd400, 2'd2);

    for (int i = 0; i < 22; i++) begin
      if (vecs[i].j) pulse_jump();
      do_tick(vecs[i].l, vecs[i].r, 1'b0, vecs[i].c);
      nm = $sformatf("vec%0d", i);
      check(nm, vecs[i].ex, vecs[i].ey, vecs[i].es);
    end

    // ---- Jump request while falling --------------------------------------
`ifdef DOUBLE_JUMP_EN
    pulse_jump();
    do_tick(1'b0, 1'b0, 1'b0, 4'b0000);
    check("air_jump_taken", 10'd40, 9'd325, 2'd1);
    pulse_jump();
    do_tick(1'b0, 1'b0, 1'b0, 4'b0000);
    check("second_air_jump_ignored", 10'd40, 9'd313, 2'd1);
    do_tick(1'b0, 1'b0, 1'b0, 4'b0010);
    check("air_head_bump", 10'd40, 9'd313, 2'd2);
    ground_y = 9'd313;
`else
    pulse_jump();
    do_tick(1'b0, 1'b0, 1'b0, 4'b0000);
    check("air_jump_discarded", 10'd40, 9'd325, 2'd2);
    ground_y = 9'd325;
`endif
    do_tick(1'b0, 1'b0, 1'b0, 4'b0001);
    check("land_after_air", 10'd40, ground_y, 2'd0);
    do_tick(1'b0, 1'b0, 1'b0, 4'b0001);
    check("air_req_not_carried", 10'd40, ground_y, 2'd0);

    // ---- Horizontal clamping and side blocking -----------------------------
    for (int i = 0; i < 183; i++) do_tick(1'b0, 1'b1, 1'b0, 4'b0001);
    check("walk_right_589", 10'd589, ground_y, 2'd0);
    do_tick(1'b0, 1'b1, 1'b0, 4'b0101);
    check("right_blocked", 10'd589, ground_y, 2'd0);
    do_tick(1'b0, 1'b1, 1'b0, 4'b0001);
    check("right_592", 10'd592, ground_y, 2'd0);
    do_tick(1'b0, 1'b1, 1'b0, 4'b0001);
    check("right_clamp_593", 10'd593, ground_y, 2'd0);
    do_tick(1'b0, 1'b1, 1'b0, 4'b0001);
    check("right_clamp_hold", 10'd593, ground_y, 2'd0);
    for (int i = 0; i < 197; i++) do_tick(1'b1, 1'b0, 1'b0, 4'b0001);
    check("walk_left_2", 10'd2, ground_y, 2'd0);
    do_tick(1'b1, 1'b0, 1'b0, 4'b1001);
    check("left_blocked", 10'd2, ground_y, 2'd0);
    do_tick(1'b1, 1'b0, 1'b0, 4'b0001);
    check("left_clamp_0", 10'd0, ground_y, 2'd0);
    do_tick(1'b1, 1'b0, 1'b0, 4'b0001);
    check("left_clamp_hold", 10'd0, ground_y, 2'd0);
    do_tick(1'b1, 1'b1, 1'b0, 4'b0001);
    check("both_keys_at_0", 10'd0, ground_y, 2'd0);
    do_tick(1'b0, 1'b1, 1'b0, 4'b0001);
    check("right_from_0", 10'd3, ground_y, 2'd0);
    do_tick(1'b1, 1'b1, 1'b0, 4'b0001);
    check("both_keys_hold", 10'd3, ground_y, 2'd0);

    // ---- Long fall to the bottom clamp, gravity up to terminal speed -------
    do_tick(1'b0, 1'b0, 1'b0, 4'b0000);
    check("walk_off_ledge", 10'd3, ground_y, 2'd2);
    mdl_y  = {1'b0, ground_y};
    mdl_vy = 5'd0;
    landed = 1'b0;
    for (int i = 0; i < 60 && !landed; i++) begin
      do_tick(1'b0, 1'b0, 1'b0, 4'b0000);
      if (mdl_y == 10'd439) begin
        landed = 1'b1;
        check("land_at_y_max", 10'd3, 9'd439, 2'd0);
      end else begin
        mdl_y  = (mdl_y + 10'(mdl_vy) > 10'd439) ? 10'd439 : mdl_y + 10'(mdl_vy);
        mdl_vy = (mdl_vy + 5'd1 > 5'd8) ? 5'd8 : mdl_vy + 5'd1;
        nm = $sformatf("fall_step%0d", i);
        check(nm, 10'd3, mdl_y[8:0], 2'd2);
      end
    end
    n_checks++;
    if (!landed) begin
      n_fails++;
      $display("FAIL fall_budget: landed=%0b required 1 within 60 ticks", landed);
    end
    do_tick(1'b0, 1'b0, 1'b0, 4'b0000);
    check("stay_at_y_max", 10'd3, 9'd439, 2'd0);

    // ---- Jump edge on the tick cycle, then reset in mid-jump ---------------
    do_tick(1'b0, 1'b0, 1'b1, 4'b0001);
    check("jump_edge_on_tick", 10'd3, 9'd439, 2'd1);
    do_tick(1'b0, 1'b0, 1'b0, 4'b0000);
    check("rise_from_439", 10'd3, 9'd427, 2'd1);
    pulse_jump();
    do_reset();
    check("reset_mid_jump", 10'd40, 9'd400, 2'd2);
    do_tick(1'b0, 1'b0, 1'b0, 4'b0001);
    check("land_after_reset", 10'd40, 9'd400, 2'd0);
    do_tick(1'b0, 1'b0, 1'b0, 4'b0001);
    check("req_dropped_by_reset", 10'd40, 9'd400, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
